player_bullet: RTL and testbench

Player laser stage, directly downstream of the player movement block: consumes the frame-latched `player_x`/`player_y` and the debounced fire button. It launches a single bullet from the centre-top of the player sprite and moves it upward on each `clk_move` strobe. It retires the bullet on a collision `hit` or when it leaves the top of the playfield, then enforces a frame-counted cooldown. Outputs are frame-latched for the renderer and collision logic.

---
 rtl/player_bullet.sv | 111 +++++++++++
 tb/tb_player_bullet.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Player laser: single bullet launched from the sprite top-centre, frame-latched outputs.
// Optional build macro PLAYER_BULLET_AUTOFIRE_EN: launch on fire level instead of edge.
module player_bullet #(
  parameter int BULLET_STEP         = 4,
  parameter int BULLET_W            = 2,
  parameter int BULLET_H            = 8,
  parameter int SPRITE_WIDTH_SCALED = 32,
  parameter int TOP_Y               = 16,
  parameter int COOLDOWN_FRAMES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_move,
  input  logic       frame,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       shot_fired,
  output logic       fire_ready
);

  localparam logic [9:0] X_OFF      = 10'((SPRITE_WIDTH_SCALED - BULLET_W) / 2);
  localparam logic [9:0] H_PX       = 10'(BULLET_H);
  localparam logic [9:0] STEP_PX    = 10'(BULLET_STEP);
  localparam logic [9:0] LAUNCH_MIN = 10'(TOP_Y + BULLET_H);
  localparam logic [9:0] RETIRE_LIM = 10'(TOP_Y + BULLET_STEP);
  localparam logic [5:0] CD_INIT    = 6'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    READY,
    FLYING,
    COOLDOWN
  } state_t;

  state_t     state;
  logic [9:0] x_temp;
  logic [9:0] y_temp;
  logic [5:0] cd_cnt;
  logic       fire_trig;
  logic       launch;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign fire_trig = fire;
`else
  logic fire_prev;
  assign fire_trig = fire & ~fire_prev;
`endif

  assign launch     = (state == READY) && fire_trig
                      && (player_y >= LAUNCH_MIN);
  assign fire_ready = (state == READY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= READY;
      x_temp        <= '0;
      y_temp        <= '0;
      cd_cnt        <= '0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      shot_fired    <= 1'b0;
`ifndef PLAYER_BULLET_AUTOFIRE_EN
      fire_prev     <= 1'b1;
`endif
    end else begin
      shot_fired <= launch;
`ifndef PLAYER_BULLET_AUTOFIRE_EN
      fire_prev  <= fire;
`endif
      // latch sees pre-update working values
      if (frame) begin
        bullet_x      <= x_temp;
        bullet_y      <= y_temp;
        bullet_active <= (state == FLYING);
      end
      unique case (state)
        READY: begin
          if (launch) begin
            x_temp <= player_x + X_OFF;
            y_temp <= player_y - H_PX;
            state  <= FLYING;
          end
        end
        FLYING: begin
          if (hit) begin
            state  <= COOLDOWN;
            cd_cnt <= CD_INIT;
          end else if (clk_move) begin
            if (y_temp < RETIRE_LIM) begin
              state  <= COOLDOWN;
              cd_cnt <= CD_INIT;
            end else begin
              y_temp <= y_temp - STEP_PX;
            end
          end
        end
        COOLDOWN: begin
          if (cd_cnt == 6'd0) state <= READY;
          else if (frame)     cd_cnt <= cd_cnt - 6'd1;
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: frame-latch scoreboard plus directed launch/flight checks.
module tb_player_bullet;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_move;
  logic       frame;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       shot_fired;
  logic       fire_ready;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
  } latch_t;

  latch_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     shots  = 0;

  player_bullet dut (
    .clk(clk), .rst(rst), .clk_move(clk_move), .frame(frame),
    .fire(fire), .player_x(player_x), .player_y(player_y), .hit(hit),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .shot_fired(shot_fired),
    .fire_ready(fire_ready)
  );

  always #5 clk = ~clk;

  // scoreboard monitor: one expected latch entry per frame strobe
  always @(posedge clk) begin
    if (frame && rst) begin
      latch_t e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL latch_underflow: frame with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (bullet_x !== e.x || bullet_y !== e.y || bullet_active !== e.act) begin
          errors++;
          $display("FAIL latch: got x=%0d y=%0d act=%0b want x=%0d y=%0d act=%0b",
                   bullet_x, bullet_y, bullet_active, e.x, e.y, e.act);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (shot_fired === 1'b1) shots++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_frame(input logic [9:0] x, input logic [9:0] y,
                          input logic a, input logic mv = 1'b0);
    exp_q.push_back('{x: x, y: y, act: a});
    frame    = 1'b1;
    clk_move = mv;
    tick();
    frame    = 1'b0;
    clk_move = 1'b0;
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    clk_move = 1'b0;
    frame    = 1'b0;
    fire     = 1'b1;
    hit      = 1'b0;
    player_x = 10'd100;
    player_y = 10'd440;
    tick(2);
    chk("rst_bx", bullet_x, 0);
    chk("rst_by", bullet_y, 0);
    chk("rst_act", bullet_active, 0);
    chk("rst_shot", shot_fired, 0);
    chk("rst_ready", fire_ready, 1);

    // fire held through reset release must not launch
    rst = 1'b1;
    tick(4);
    chk("held_no_shot", shots, 0);
    chk("held_ready", fire_ready, 1);
    fire = 1'b0;
    tick();

    // basic launch
    pulse_fire();
    tick();
    chk("launch_shot", shots, 1);
    chk("launch_busy", fire_ready, 0);
    do_frame(10'd115, 10'd432, 1'b1);
    player_x = 10'd200;
    pulse_fire();
    chk("fly_fire_drop", shots, 1);

    // 104 strobes reach the top edge
    clk_move = 1'b1;
    tick(104);
    clk_move = 1'b0;
    do_frame(10'd115, 10'd16, 1'b1);
    clk_move = 1'b1;
    tick();
    clk_move = 1'b0;
    chk("top_cooldown", fire_ready, 0);
    do_frame(10'd115, 10'd16, 1'b0);
    pulse_fire();
    chk("cd_fire_drop", shots, 1);

    // hold fire across return to READY
    fire = 1'b1;
    repeat (7) do_frame(10'd115, 10'd16, 1'b0);
    tick(2);
    chk("cd_ready", fire_ready, 1);
    tick(3);
    chk("held_ready_no_shot", shots, 1);
    fire = 1'b0;
    tick();
    pulse_fire();
    tick();
    chk("repress_shot", shots, 2);

    // frame and clk_move together: latch sees pre-move value
    do_frame(10'd215, 10'd432, 1'b1, 1'b1);
    clk_move = 1'b1;
    tick();
    hit = 1'b1;
    tick();
    hit      = 1'b0;
    clk_move = 1'b0;
    do_frame(10'd215, 10'd424, 1'b0);
    repeat (6) do_frame(10'd215, 10'd424, 1'b0);
    tick(2);
    chk("hit_cd_7", fire_ready, 0);
    do_frame(10'd215, 10'd424, 1'b0);
    tick(2);
    chk("hit_cd_8", fire_ready, 1);

    // hit outside FLYING is ignored
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
    chk("idle_hit", fire_ready, 1);

    // launch limit boundary
    player_y = 10'd23;
    pulse_fire();
    tick();
    chk("low_no_shot", shots, 2);
    chk("low_ready", fire_ready, 1);
    player_y = 10'd24;
    player_x = 10'd0;
    pulse_fire();
    tick();
    chk("lim_shot", shots, 3);
    do_frame(10'd15, 10'd16, 1'b1);

    // asynchronous reset mid-flight
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bx", bullet_x, 0);
    chk("mid_rst_by", bullet_y, 0);
    chk("mid_rst_act", bullet_active, 0);
    chk("mid_rst_ready", fire_ready, 1);
    tick();
    rst = 1'b1;
    tick(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
